// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game sequencer.
// The speed-up period helper is only referenced when SNAKE_SPEEDUP_EN is defined.
package snake_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_START   = 2'b00,
    ST_PLAY    = 2'b01,
    ST_DIE     = 2'b10,
    ST_RESTART = 2'b11
  } status_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   opposite = DIR_DOWN;
      DIR_DOWN: opposite = DIR_UP;
      DIR_LEFT: opposite = DIR_RIGHT;
      default:  opposite = DIR_LEFT;
    endcase
  endfunction

  // Move period shrinks with length; the floor is checked before subtracting so it never wraps.
  function automatic logic [CNT_W-1:0] calc_period(input logic [CNT_W-1:0] base,
                                                   input logic [CNT_W-1:0] step,
                                                   input logic [CNT_W-1:0] pmin,
                                                   input logic [6:0]       len);
    logic [6:0]       extra;
    logic [CNT_W-1:0] red;
    extra = (len < 7'd3) ? 7'd0 : len - 7'd3;
    red   = step * {{(CNT_W-7){1'b0}}, extra};
    if (base <= pmin || red >= base - pmin) calc_period = pmin;
    else                                    calc_period = base - red;
  endfunction

endpackage

// File: rtl/snake_game_sequencer_dir_queue.sv
// Two-entry direction FIFO with the reversal/duplicate filter applied on push.
// Push has no ready: a press that fails the filter or finds no room is silently dropped.
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  dir_t push_dir,
  input  logic pop,
  input  logic flush,
  input  dir_t cur_dir,
  output dir_t head,
  output logic empty,
  output logic full
);

  dir_t       slot0, slot1, slot0_n, slot1_n, ref_dir;
  logic [1:0] count, count_n, count_pop;
  logic       do_pop, accept;

  // A pop never changes the reference: the popped entry becomes cur_dir.
  always_comb begin
    ref_dir = cur_dir;
    if (count == 2'd2)      ref_dir = slot1;
    else if (count == 2'd1) ref_dir = slot0;
    do_pop    = pop && (count != 2'd0);
    count_pop = count - {1'b0, do_pop};
    accept    = push && (push_dir != ref_dir) && (push_dir != opposite(ref_dir))
                && (count_pop != 2'd2);
    slot0_n   = do_pop ? slot1 : slot0;
    slot1_n   = slot1;
    count_n   = count_pop;
    if (accept) begin
      if (count_pop == 2'd0) slot0_n = push_dir;
      else                   slot1_n = push_dir;
      count_n = count_pop + 2'd1;
    end
    if (flush) count_n = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      slot0 <= DIR_RIGHT;
      slot1 <= DIR_RIGHT;
    end else begin
      count <= count_n;
      slot0 <= slot0_n;
      slot1 <= slot1_n;
    end
  end

  assign head  = slot0;
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-loop sequencer: move tick, buffered direction keys, death flash and restart.
// Define SNAKE_SPEEDUP_EN to make the move period shrink with snake length.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter logic [CNT_W-1:0] TICK_BASE     = 24'd2_500_000,
  parameter logic [CNT_W-1:0] TICK_STEP     = 24'd50_000,
  parameter logic [CNT_W-1:0] TICK_MIN      = 24'd750_000,
  parameter logic [CNT_W-1:0] FLASH_PERIOD  = 24'd12_500_000,
  parameter logic [7:0]       FLASH_TOGGLES = 8'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_press,
  input  logic       right_press,
  input  logic       up_press,
  input  logic       down_press,
  input  logic [6:0] len,
  input  logic       hit_wall,
  input  logic       hit_body,
  output logic       move_tick,
  output logic [1:0] dir,
  output logic [1:0] game_status,
  output logic       die_flash,
  output logic       restart
);

  status_t          status, status_n;
  dir_t             dir_q, press_dir, q_head;
  logic [CNT_W-1:0] tick_cnt, period_q, period_next, flash_cnt;
  logic [7:0]       toggle_cnt;
  logic             press_any, push_en, flush, collide, tick_due, tick;
  logic             flash_due, last_toggle, q_empty, unused_q_full;

`ifdef SNAKE_SPEEDUP_EN
  assign period_next = calc_period(TICK_BASE, TICK_STEP, TICK_MIN, len);
`else
  logic unused_cfg;
  assign period_next = TICK_BASE;
  assign unused_cfg  = ^{len, TICK_STEP, TICK_MIN};
`endif

  always_comb begin
    press_any = up_press | down_press | left_press | right_press;
    press_dir = DIR_RIGHT;
    if (up_press)        press_dir = DIR_UP;
    else if (down_press) press_dir = DIR_DOWN;
    else if (left_press) press_dir = DIR_LEFT;
    collide     = (status == ST_PLAY) && (hit_wall | hit_body);
    tick_due    = (status == ST_PLAY) && (tick_cnt == period_q - 24'd1);
    tick        = tick_due && !collide;
    flash_due   = (status == ST_DIE) && (flash_cnt == FLASH_PERIOD - 24'd1);
    last_toggle = flash_due && (toggle_cnt == FLASH_TOGGLES - 8'd1);
    push_en     = press_any && ((status == ST_START) || (status == ST_PLAY));
    flush       = collide || (status == ST_RESTART);
    restart     = (status == ST_RESTART);
    status_n    = status;
    case (status)
      ST_START:   if (press_any)   status_n = ST_PLAY;
      ST_PLAY:    if (collide)     status_n = ST_DIE;
      ST_DIE:     if (last_toggle) status_n = ST_RESTART;
      ST_RESTART:                  status_n = ST_START;
      default:                     status_n = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      status     <= ST_START;
      move_tick  <= 1'b0;
      dir_q      <= DIR_RIGHT;
      die_flash  <= 1'b0;
      tick_cnt   <= '0;
      period_q   <= TICK_BASE;
      flash_cnt  <= '0;
      toggle_cnt <= '0;
    end else begin
      status    <= status_n;
      move_tick <= tick;
      if (tick && !q_empty)          dir_q <= q_head;
      else if (status == ST_RESTART) dir_q <= DIR_RIGHT;
      if (status == ST_PLAY && !collide && !tick_due) tick_cnt <= tick_cnt + 24'd1;
      else                                            tick_cnt <= '0;
      // The period is latched per interval so a len change only affects the next one.
      if (status == ST_START || tick) period_q <= period_next;
      if (status == ST_DIE) begin
        if (flash_due) begin
          flash_cnt  <= '0;
          toggle_cnt <= toggle_cnt + 8'd1;
          die_flash  <= last_toggle ? 1'b0 : ~die_flash;
        end else begin
          flash_cnt  <= flash_cnt + 24'd1;
        end
      end else begin
        flash_cnt  <= '0;
        toggle_cnt <= '0;
        die_flash  <= 1'b0;
      end
    end
  end

  snake_dir_queue u_dir_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push_en),
    .push_dir (press_dir),
    .pop      (tick),
    .flush    (flush),
    .cur_dir  (dir_q),
    .head     (q_head),
    .empty    (q_empty),
    .full     (unused_q_full)
  );

  assign dir         = dir_q;
  assign game_status = status;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Bench for snake_game_sequencer: directed scenarios plus random traffic against a
// time-based behavioural model; honours SNAKE_SPEEDUP_EN for the expected move period.
module tb_snake_game_sequencer;

  localparam int TB = 20;
  localparam int TS = 2;
  localparam int TM = 8;
  localparam int FP = 4;
  localparam int FT = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       left_press = 1'b0, right_press = 1'b0, up_press = 1'b0, down_press = 1'b0;
  logic [6:0] len = 7'd3;
  logic       hit_wall = 1'b0, hit_body = 1'b0;
  logic       move_tick, die_flash, restart;
  logic [1:0] dir, game_status;

  snake_game_sequencer #(
    .TICK_BASE     (24'd20),
    .TICK_STEP     (24'd2),
    .TICK_MIN      (24'd8),
    .FLASH_PERIOD  (24'd4),
    .FLASH_TOGGLES (8'd6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .left_press  (left_press),
    .right_press (right_press),
    .up_press    (up_press),
    .down_press  (down_press),
    .len         (len),
    .hit_wall    (hit_wall),
    .hit_body    (hit_body),
    .move_tick   (move_tick),
    .dir         (dir),
    .game_status (game_status),
    .die_flash   (die_flash),
    .restart     (restart)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // behavioural model: absolute-time schedule for ticks and flashes
  int         m_status = 0;
  logic [1:0] m_dir = 2'd3;
  logic [1:0] exp_q[$];
  logic       m_tick = 1'b0;
  logic       m_flash = 1'b0;
  int         m_cyc = 0;
  int         m_int_start = 0;
  int         m_p = TB;
  int         m_die_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, m_cyc);
    end
  endtask

  function automatic int model_period();
    int v;
`ifdef SNAKE_SPEEDUP_EN
    int l;
    l = (int'(len) < 3) ? 3 : int'(len);
    v = TB - TS * (l - 3);
    if (v < TM) v = TM;
`else
    v = TB;
`endif
    return v;
  endfunction

  task automatic model_offer(input logic [1:0] pd);
    logic [1:0] r;
    r = (exp_q.size() != 0) ? exp_q[$] : m_dir;
    if (pd != r && pd != (r ^ 2'b01) && exp_q.size() < 2) exp_q.push_back(pd);
  endtask

  task automatic model_step();
    logic       pv;
    logic [1:0] pd;
    int         n;
    pv = up_press | down_press | left_press | right_press;
    pd = up_press ? 2'd0 : down_press ? 2'd1 : left_press ? 2'd2 : 2'd3;
    n  = m_cyc + 1;
    m_tick = 1'b0;
    if (!reset) begin
      m_status = 0;
      m_dir    = 2'd3;
      m_flash  = 1'b0;
      exp_q.delete();
    end else begin
      case (m_status)
        0: if (pv) begin
          model_offer(pd);
          m_status    = 1;
          m_int_start = n;
          m_p         = model_period();
        end
        1: if (hit_wall || hit_body) begin
          m_status    = 2;
          m_die_start = n;
          exp_q.delete();
        end else begin
          if (m_cyc == m_int_start + m_p - 1) begin
            m_tick = 1'b1;
            if (exp_q.size() != 0) m_dir = exp_q.pop_front();
            m_int_start = n;
            m_p         = model_period();
          end
          if (pv) model_offer(pd);
        end
        2: if (n - m_die_start == FP * FT) begin
          m_status = 3;
          m_flash  = 1'b0;
        end else begin
          m_flash = (((n - m_die_start) / FP) % 2) == 1;
        end
        default: begin
          m_status = 0;
          m_dir    = 2'd3;
          exp_q.delete();
        end
      endcase
    end
    m_cyc = n;
  endtask

  // compare process: DUT against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("game_status", {30'd0, game_status}, m_status);
      check("dir", {30'd0, dir}, {30'd0, m_dir});
      check("move_tick", {31'd0, move_tick}, {31'd0, m_tick});
      check("die_flash", {31'd0, die_flash}, {31'd0, m_flash});
      check("restart", {31'd0, restart}, (m_status == 3) ? 1 : 0);
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    up_press = u; down_press = d; left_press = l; right_press = r;
    cycle();
    up_press = 1'b0; down_press = 1'b0; left_press = 1'b0; right_press = 1'b0;
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!move_tick && k < 64);
    check("tick_seen", {31'd0, move_tick}, 1);
  endtask

  int k;
  int lens[4] = '{10, 127, 5, 0};
`ifdef SNAKE_SPEEDUP_EN
  int exp_p[4] = '{8, 8, 16, 20};
`else
  int exp_p[4] = '{20, 20, 20, 20};
`endif

  initial begin
    reset = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    check("rst_status", {30'd0, game_status}, 0);
    check("rst_dir", {30'd0, dir}, 3);
    check("rst_tick", {31'd0, move_tick}, 0);
    check("rst_flash", {31'd0, die_flash}, 0);
    check("rst_restart", {31'd0, restart}, 0);
    reset = 1'b1;
    repeat (3) cycle();

    // first play: up press, ticks every 20 cycles at len 3
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_play", {30'd0, game_status}, 1);
    wait_tick(k);
    check("t1_first_tick_gap", k, 20);
    check("t1_dir_up", {30'd0, dir}, 0);
    wait_tick(k);
    check("t1_second_tick_gap", k, 20);

    // filter: opposite and equal rejected, two queued, third dropped
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_tick(k);
    check("t2_dir_right", {30'd0, dir}, 3);
    wait_tick(k);
    check("t2_dir_down", {30'd0, dir}, 1);
    wait_tick(k);
    check("t2_dir_hold", {30'd0, dir}, 1);

    // simultaneous presses: priority up over right
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_tick(k);
    check("t3_dir_left", {30'd0, dir}, 2);
    press(1'b1, 1'b0, 1'b0, 1'b1);
    wait_tick(k);
    check("t3_dir_up", {30'd0, dir}, 0);
    wait_tick(k);
    check("t3_dir_up_hold", {30'd0, dir}, 0);

    // length-dependent period, resampled at the tick
    for (int i = 0; i < 4; i++) begin
      len = lens[i];
      wait_tick(k);
      wait_tick(k);
      check("t4_period", k, exp_p[i]);
    end

    // collision on the due cycle suppresses the tick; flash and restart sequence
    len = 7'd3;
    wait_tick(k);
    repeat (19) cycle();
    hit_wall = 1'b1;
    cycle();
    hit_wall = 1'b0;
    check("t5_no_tick", {31'd0, move_tick}, 0);
    check("t5_die", {30'd0, game_status}, 2);
    for (int j = 1; j <= 25; j++) begin
      cycle();
      if (j == 3)  check("t5_flash_j3", {31'd0, die_flash}, 0);
      if (j == 4)  check("t5_flash_j4", {31'd0, die_flash}, 1);
      if (j == 8)  check("t5_flash_j8", {31'd0, die_flash}, 0);
      if (j == 20) check("t5_flash_j20", {31'd0, die_flash}, 1);
      if (j == 23) check("t5_die_j23", {30'd0, game_status}, 2);
      if (j == 24) begin
        check("t5_restart_status", {30'd0, game_status}, 3);
        check("t5_restart_pulse", {31'd0, restart}, 1);
        check("t5_restart_flash", {31'd0, die_flash}, 0);
      end
      if (j == 25) begin
        check("t5_start", {30'd0, game_status}, 0);
        check("t5_dir_reset", {30'd0, dir}, 3);
        check("t5_restart_low", {31'd0, restart}, 0);
      end
    end

    // reset in the middle of the flash sequence
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle();
    hit_body = 1'b1;
    cycle();
    hit_body = 1'b0;
    check("t6_die", {30'd0, game_status}, 2);
    repeat (6) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("t6_rst_status", {30'd0, game_status}, 0);
    check("t6_rst_dir", {30'd0, dir}, 3);
    check("t6_rst_flash", {31'd0, die_flash}, 0);
    check("t6_rst_tick", {31'd0, move_tick}, 0);
    check("t6_rst_restart", {31'd0, restart}, 0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_play", {30'd0, game_status}, 1);
    repeat (3) cycle();
    hit_wall = 1'b1;
    cycle();
    hit_wall = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      cycle();
      if (j == 3) check("t6_flash_j3", {31'd0, die_flash}, 0);
      if (j == 4) check("t6_flash_j4", {31'd0, die_flash}, 1);
    end
    repeat (21) cycle();
    check("t6_back_to_start", {30'd0, game_status}, 0);

    // random traffic against the model
    repeat (4000) begin
      up_press    = ($urandom_range(0, 15) == 0);
      down_press  = ($urandom_range(0, 15) == 0);
      left_press  = ($urandom_range(0, 15) == 0);
      right_press = ($urandom_range(0, 15) == 0);
      hit_wall    = ($urandom_range(0, 299) == 0);
      hit_body    = ($urandom_range(0, 299) == 0);
      reset       = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 99) == 0) len = 7'($urandom_range(0, 127));
      cycle();
    end
    up_press = 1'b0; down_press = 1'b0; left_press = 1'b0; right_press = 1'b0;
    hit_wall = 1'b0; hit_body = 1'b0; reset = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_game_sequencer.md
# snake_game_sequencer

Sequencer for the game loop. It drives the snake movement datapath and owns the game state machine:
- generates the move tick,
- buffers and filters direction key presses,
- runs the death-flash and restart sequence.

It sits between the debounced key pulses and the snake/collision logic, and replaces ad-hoc status control with one scheduled controller.

## Interface
- TICK_BASE, 2_500_000: move period in cycles at length 3
- TICK_STEP, 50_000: period reduction per body segment above 3
- TICK_MIN, 750_000: period floor
- FLASH_PERIOD, 12_500_000: cycles between die_flash toggles
- FLASH_TOGGLES, 6: toggles before restart (even)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- left_press, right_press, up_press, down_press  in  1 each  one-cycle key pulses
- len  in  7  current snake length
- hit_wall, hit_body  in  1  collision flags from snake datapath
- move_tick  out  1  one-cycle pulse: advance snake one cell
- dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right
- game_status  out  2  00 START, 01 PLAY, 10 DIE, 11 RESTART
- die_flash  out  1  blink enable during DIE
- restart  out  1  one-cycle pulse: reinitialise snake and apple

## Operation
**Reset values** (reset=0 at a clk edge): move_tick=0, dir=11, game_status=START, die_flash=0, restart=0, queue empty, counters 0. Reset applies in every state, including mid-flash.

**FSM:**
- START: any key press -> PLAY. That press is also offered to the queue.
- PLAY: hit_wall|hit_body=1 -> DIE. In the same edge the queue is flushed and the tick counter is cleared.
- DIE: die_flash toggles every FLASH_PERIOD cycles. After FLASH_TOGGLES toggles -> RESTART, with die_flash=0.
- RESTART: restart=1 for exactly this one cycle, dir set to 11, queue flushed -> START.

**Direction queue** (2 entries):
- Reference direction = newest queued entry, or dir if the queue is empty.
- A press is accepted only if it is neither equal to nor opposite the reference direction.
- Simultaneous presses: only the highest-priority one is considered, priority up > down > left > right.
- Press while full: dropped.
- Presses are accepted in START and PLAY only; ignored in DIE and RESTART.

**Tick:**
- Period P = max(TICK_MIN, TICK_BASE − TICK_STEP·(L−3)), where L = max(len,3).
- Arithmetic is 24-bit unsigned. The subtraction saturates at TICK_MIN and never wraps.
- Counter runs only in PLAY.
- On the tick edge, the queue head (if any) is popped into dir. dir is therefore valid in the same cycle move_tick=1.

## Timing
- move_tick first asserts exactly P cycles after the first PLAY cycle, then every P cycles.
- P is re-sampled at each tick. A len change takes effect from the next interval.
- Collision and tick due in the same cycle: collision wins. No move_tick, no dir pop.
- Key press to dir update: at the next tick edge. A push and a pop in the same cycle are both honoured; ordering is pop then push.
- game_status is registered and changes one edge after its cause.
- restart is high 1 cycle; START is visible the following cycle.

## Configuration
SNAKE_SPEEDUP_EN:
- Defined: P follows the length formula above.
- Undefined: P = TICK_BASE constant, len is ignored, and TICK_STEP/TICK_MIN are unused.

## Structure
**Package snake_pkg:**
- dir_t encoding (UP/DOWN/LEFT/RIGHT)
- status_t encoding (START/PLAY/DIE/RESTART)
- function opposite(dir_t)

**Sub-module snake_dir_queue:** 2-entry FIFO with the accept filter, with push/pop/flush/head/empty/full.

## Test plan
Bench parameters: TICK_BASE=20, TICK_STEP=2, TICK_MIN=8, FLASH_PERIOD=4, FLASH_TOGGLES=6, SNAKE_SPEEDUP_EN defined.

1. Reset, then up_press at cycle 5 -> PLAY at cycle 6; move_tick at 26, 46 with len=3; dir=00 at cycle 26.
2. In PLAY with dir=11, press left -> rejected. Press up then left within one interval -> next tick dir=00, following tick dir=10. A third press before a tick is dropped.
3. up_press and right_press in the same cycle with dir=10 -> only up is queued.
4. len=10 -> P=max(8,20−14)=8. len=127 -> P=8, no wrap. Without the macro, P=20 for any len.
5. hit_wall asserted in the cycle a tick is due -> no move_tick. DIE next cycle; die_flash toggles at +4,+8…+24; RESTART with restart=1 one cycle; then START with dir=11.
6. reset=0 mid-DIE -> next cycle all outputs at reset values, and the flash counter restarts from 0 after release.
